mac_result_packer: RTL and testbench

- Downstream neighbour of the MAC engine: consumes the engine's narrow per-result stream (one accumulator word per handshake) and packs words into full-width beats for the streamer's store (sink) stream.
- Handles partial beats at end of job via strobes and `last`.
- Provides a registered, backpressure-safe output slot, so engine throughput is one word per cycle while the streamer accepts.

---
 rtl/mac_result_packer.sv | 124 ++++++++++++
 tb/tb_mac_result_packer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_packer.sv
// Packs the MAC engine's narrow result stream into full-width store beats,
// with byte strobes and a last flag for a partial tail beat at end of job.
module mac_result_packer #(
    parameter int RES_WIDTH = 32,
    parameter int OUT_WIDTH = 128,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    input  logic [RES_WIDTH-1:0]   res_data_i,
    input  logic                   res_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_WIDTH-1:0]   out_data_o,
    output logic [OUT_WIDTH/8-1:0] out_strb_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   beats_o
);

    localparam int N_LANES    = OUT_WIDTH / RES_WIDTH;
    localparam int LANE_BYTES = RES_WIDTH / 8;
    localparam int STRB_WIDTH = OUT_WIDTH / 8;
    localparam int LW         = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(N_LANES - 1);

    logic [LW-1:0]         cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  pack_q, pack_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  beats_q, beats_d;

    logic                  slot_free;
    logic                  res_ready;
    logic                  accept;
    logic                  complete;
    logic [OUT_WIDTH-1:0]  merged;
    logic [STRB_WIDTH-1:0] strb_new;

    // Handshake: a transfer happens on any edge where valid && ready; ready
    // never looks at valid. A non-completing word only needs pack space, so
    // the engine keeps streaming while the output slot is blocked.
    assign slot_free = !valid_q || out_ready_i;
    assign res_ready = enable_i && !clear_i &&
                       (slot_free || ((cnt_q < LAST_LANE) && !res_last_i));
    assign accept    = res_valid_i && res_ready;
    assign complete  = (cnt_q == LAST_LANE) || res_last_i;

    always_comb begin
        merged   = pack_q;
        strb_new = '0;
        for (int l = 0; l < N_LANES; l++) begin
            if (LW'(l) == cnt_q) begin
                merged[l*RES_WIDTH +: RES_WIDTH] = res_data_i;
            end
            if (LW'(l) <= cnt_q) begin
                strb_new[l*LANE_BYTES +: LANE_BYTES] = '1;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        valid_d = valid_q;
        beats_d = beats_q;
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            beats_d = beats_q + 1'b1;
        end
        if (accept) begin
            if (complete) begin
                // A completing load overrides the drain, giving back-to-back beats.
                data_d  = merged;
                strb_d  = strb_new;
                last_d  = res_last_i;
                valid_d = 1'b1;
                cnt_d   = '0;
                pack_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                pack_d = merged;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q   <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            beats_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            beats_q <= beats_d;
        end
    end

    assign res_ready_o = res_ready;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_strb_o  = strb_q;
    assign out_last_o  = last_q;
    assign busy_o      = (cnt_q != '0) || valid_q;
    assign beats_o     = beats_q;

endmodule

// File: tb/tb_mac_result_packer.sv
// Bench for mac_result_packer: directed scenarios plus randomized jobs, with a
// word-list reference model feeding an expected-beat queue.
module tb_mac_result_packer;

    localparam int RW = 32;
    localparam int OW = 128;
    localparam int CW = 16;
    localparam int NL = OW / RW;
    localparam int SW = OW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          res_valid = 1'b0;
    logic [RW-1:0] res_data = '0;
    logic          res_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          res_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [SW-1:0] out_strb;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] beats;

    mac_result_packer #(.RES_WIDTH(RW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .res_last_i(res_last), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_strb_o(out_strb), .out_last_o(out_last),
        .busy_o(busy), .beats_o(beats)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    bit rand_mode = 1'b0;

    // Reference model: accepted words of the current beat, pending beats.
    logic [RW-1:0] cur_q[$];
    logic [OW-1:0] exp_q[$];
    logic [SW-1:0] exp_strb_q[$];
    logic          exp_last_q[$];
    logic [CW-1:0] exp_beats = '0;
    logic [OW-1:0] obs_data[$];
    logic [SW-1:0] obs_strb[$];
    logic          obs_last[$];
    bit            hold = 1'b0;
    logic [OW-1:0] held_data;
    logic [SW-1:0] held_strb;
    logic          held_last;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [RW-1:0] pat(input int k);
        return RW'(32'h11111111 * k);
    endfunction

    task automatic rand_knobs();
        enable    = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        clear     = ($urandom_range(0, 49) == 0);
    endtask

    task automatic send(input logic [RW-1:0] w, input logic l, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        res_valid = 1'b1;
        res_data = w;
        res_last = l;
        for (int i = 0; i < 1000 && !ok; i++) begin
            #4;
            ok = res_ready && !clear;
            @(negedge clk);
            waited++;
            if (rand_mode) rand_knobs();
        end
        check("send_accepted", OW'(ok), OW'(1));
        res_valid = 1'b0;
        res_last = 1'b0;
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        logic [OW-1:0] d;
        logic [SW-1:0] s;
        forever begin
            @(negedge clk);
            #4;
            if (rst || clear) begin
                if (clear) check("ready_low_on_clear", OW'(res_ready), OW'(0));
                cur_q.delete();
                exp_q.delete();
                exp_strb_q.delete();
                exp_last_q.delete();
                exp_beats = '0;
                hold = 1'b0;
            end else begin
                check("valid_vs_model", OW'(out_valid), OW'(exp_q.size() != 0));
                check("busy_vs_model", OW'(busy), OW'((cur_q.size() != 0) || (exp_q.size() != 0)));
                check("beats_vs_model", OW'(beats), OW'(exp_beats));
                if (!enable) check("ready_low_when_disabled", OW'(res_ready), OW'(0));
                if (hold) begin
                    check("hold_data", out_data, held_data);
                    check("hold_strb", OW'(out_strb), OW'(held_strb));
                    check("hold_last", OW'(out_last), OW'(held_last));
                end
                if (out_valid && out_ready) begin
                    obs_data.push_back(out_data);
                    obs_strb.push_back(out_strb);
                    obs_last.push_back(out_last);
                    check("beat_expected", OW'(exp_q.size() != 0), OW'(1));
                    if (exp_q.size() != 0) begin
                        check("beat_data", out_data, exp_q.pop_front());
                        check("beat_strb", OW'(out_strb), OW'(exp_strb_q.pop_front()));
                        check("beat_last", OW'(out_last), OW'(exp_last_q.pop_front()));
                    end
                    exp_beats = exp_beats + 1'b1;
                end
                hold = out_valid && !out_ready;
                held_data = out_data;
                held_strb = out_strb;
                held_last = out_last;
                if (res_valid && res_ready) begin
                    cur_q.push_back(res_data);
                    if (cur_q.size() == NL || res_last) begin
                        d = '0;
                        foreach (cur_q[i]) d = d | (OW'(cur_q[i]) << (i * RW));
                        s = SW'((32'd1 << (cur_q.size() * (RW / 8))) - 32'd1);
                        exp_q.push_back(d);
                        exp_strb_q.push_back(s);
                        exp_last_q.push_back(res_last);
                        cur_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, tot, base, len;
        repeat (3) @(negedge clk);
        #4;
        check("rst_valid", OW'(out_valid), OW'(0));
        check("rst_data", out_data, OW'(0));
        check("rst_strb", OW'(out_strb), OW'(0));
        check("rst_beats", OW'(beats), OW'(0));
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;

        // Full beats, no input stall.
        base = obs_data.size();
        tot = 0;
        for (int k = 1; k <= 8; k++) begin
            send(pat(k), k == 8, w);
            tot += w;
        end
        check("full_no_stall", OW'(tot), OW'(8));
        repeat (3) @(negedge clk);
        #4;
        check("full_beats", OW'(beats), OW'(2));
        check("full_b1_data", obs_data[base], 128'h44444444_33333333_22222222_11111111);
        check("full_b1_strb", OW'(obs_strb[base]), OW'(16'hFFFF));
        check("full_b1_last", OW'(obs_last[base]), OW'(0));
        check("full_b2_data", obs_data[base+1], 128'h88888888_77777777_66666666_55555555);
        check("full_b2_last", OW'(obs_last[base+1]), OW'(1));
        @(negedge clk);

        // Partial tail and single-word job.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        base = obs_data.size();
        for (int k = 1; k <= 6; k++) send(pat(k), k == 6, w);
        send(32'hAAAAAAAA, 1'b1, w);
        repeat (3) @(negedge clk);
        #4;
        check("tail_data", obs_data[base+1], 128'h00000000_00000000_66666666_55555555);
        check("tail_strb", OW'(obs_strb[base+1]), OW'(16'h00FF));
        check("tail_last", OW'(obs_last[base+1]), OW'(1));
        check("single_data", obs_data[base+2], 128'h00000000_00000000_00000000_AAAAAAAA);
        check("single_strb", OW'(obs_strb[base+2]), OW'(16'h000F));
        @(negedge clk);

        // Backpressure: 10 stalled cycles after the first beat.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 1; k <= 4; k++) send(pat(k), 1'b0, w);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            res_valid = 1'b1;
            res_data = pat(5 + ((c < 3) ? c : 3));
            res_last = (c >= 3);
            #4;
            check("bp_ready", OW'(res_ready), OW'(c < 3));
            check("bp_valid", OW'(out_valid), OW'(1));
            check("bp_data", out_data, 128'h44444444_33333333_22222222_11111111);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #4;
        check("bp_release_ready", OW'(res_ready), OW'(1));
        @(negedge clk);
        res_valid = 1'b0;
        res_last = 1'b0;
        #4;
        check("bp_b2b_valid", OW'(out_valid), OW'(1));
        check("bp_b2b_data", out_data, 128'h88888888_77777777_66666666_55555555);
        check("bp_b2b_last", OW'(out_last), OW'(1));
        repeat (3) @(negedge clk);

        // Clear mid-job drops the coincident word.
        base = obs_data.size();
        send(32'hA1A1A1A1, 1'b0, w);
        send(32'hA2A2A2A2, 1'b0, w);
        res_valid = 1'b1;
        res_data = 32'hDEADBEEF;
        clear = 1'b1;
        #4;
        check("clr_ready", OW'(res_ready), OW'(0));
        @(negedge clk);
        clear = 1'b0;
        res_valid = 1'b0;
        #4;
        check("clr_busy", OW'(busy), OW'(0));
        check("clr_beats", OW'(beats), OW'(0));
        @(negedge clk);
        for (int k = 0; k < 4; k++) send(RW'(32'hB0B0B0B0 + k), k == 3, w);
        repeat (3) @(negedge clk);
        #4;
        check("clr_next_data", obs_data[base], 128'hB0B0B0B3_B0B0B0B2_B0B0B0B1_B0B0B0B0);
        @(negedge clk);

        // Enable gating keeps partial contents.
        base = obs_data.size();
        send(32'h12345678, 1'b0, w);
        enable = 1'b0;
        res_valid = 1'b1;
        res_data = 32'h9ABCDEF0;
        res_last = 1'b1;
        #4;
        check("en_ready", OW'(res_ready), OW'(0));
        check("en_busy", OW'(busy), OW'(1));
        repeat (3) @(negedge clk);
        enable = 1'b1;
        send(32'h9ABCDEF0, 1'b1, w);
        repeat (3) @(negedge clk);
        #4;
        check("en_data", obs_data[base], 128'h00000000_00000000_9ABCDEF0_12345678);
        check("en_strb", OW'(obs_strb[base]), OW'(16'h00FF));
        @(negedge clk);

        // Reset while a beat is pending.
        out_ready = 1'b0;
        send(32'h55AA55AA, 1'b1, w);
        #4;
        check("rst2_pre_valid", OW'(out_valid), OW'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst2_valid", OW'(out_valid), OW'(0));
        check("rst2_data", out_data, OW'(0));
        check("rst2_strb", OW'(out_strb), OW'(0));
        check("rst2_last", OW'(out_last), OW'(0));
        check("rst2_beats", OW'(beats), OW'(0));
        check("rst2_busy", OW'(busy), OW'(0));
        @(negedge clk);
        out_ready = 1'b1;

        // Randomized jobs with random enable, backpressure and clears.
        rand_mode = 1'b1;
        for (int j = 0; j < 60; j++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                send(RW'($urandom), i == len - 1, w);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    rand_knobs();
                end
            end
        end
        rand_mode = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        clear = 1'b0;
        repeat (10) @(negedge clk);
        #4;
        check("drain_empty", OW'(exp_q.size()), OW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
